// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: datapath width,
// per-stage control bundle layouts and the skid-buffer state encoding.
package pipe_pkg;

    // Architectural datapath width of the MIPS core.
    localparam int WIDTH = 32;

    // Control carried from ID into EXE.
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alucontrol;
    } ctrl_id2exe_t;

    // Control carried from EXE into MEM.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_exe2mem_t;

    // Control carried from MEM into WB.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } ctrl_mem2wb_t;

    localparam int CTRL_ID2EXE_W  = $bits(ctrl_id2exe_t);
    localparam int CTRL_EXE2MEM_W = $bits(ctrl_exe2mem_t);
    localparam int CTRL_MEM2WB_W  = $bits(ctrl_mem2wb_t);

    // Occupancy of the two-entry skid register (main entry M, skid entry S).
    localparam logic [1:0] ST_EMPTY = 2'd0;   // nothing held
    localparam logic [1:0] ST_FULL  = 2'd1;   // M holds a beat
    localparam logic [1:0] ST_FULL2 = 2'd2;   // M and S both hold beats

    // Expected next value of a saturating up-counter.
    function automatic logic [63:0] sat_next(input logic [63:0] cur, input logic [63:0] max_val);
        logic [63:0] nxt;
        if (cur >= max_val) begin
            nxt = max_val;
        end else begin
            nxt = cur + 64'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating performance counter with a synchronous active-low clear.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count enabled cycles, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two MIPS stages. Carries a control and a
// data bundle with valid/ready backpressure, optional skid entry for full
// throughput with a registered in_ready, synchronous flush, and saturating
// stall/bubble counters. Control is forced to zero whenever no beat is shown,
// so a bubble can never trigger a downstream write.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W         = 8,
    parameter int DATA_W         = 128,
    parameter int SKID           = 1,
    parameter int FLUSH_CLR_DATA = 0,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              in_ready_s;
    logic              m_valid_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic [CTRL_W-1:0] m_ctrl_r;
    logic [DATA_W-1:0] m_data_r;

    assign in_fire_s  = in_valid & in_ready_s;
    assign out_fire_s = m_valid_s & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]        state_r;
            logic [CTRL_W-1:0] s_ctrl_r;
            logic [DATA_W-1:0] s_data_r;

            // Two-entry occupancy machine: M feeds the output, S absorbs the
            // one beat that arrives while downstream stalls.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_r  <= ST_EMPTY;
                    m_ctrl_r <= '0;
                    m_data_r <= '0;
                    s_ctrl_r <= '0;
                    s_data_r <= '0;
                end else if (flush) begin
                    state_r  <= ST_EMPTY;
                    m_ctrl_r <= '0;
                    s_ctrl_r <= '0;
                    if (FLUSH_CLR_DATA != 0) begin
                        m_data_r <= '0;
                        s_data_r <= '0;
                    end
                end else begin
                    case (state_r)
                        ST_EMPTY: begin
                            if (in_fire_s) begin
                                m_ctrl_r <= in_ctrl;
                                m_data_r <= in_data;
                                state_r  <= ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (in_fire_s && out_fire_s) begin
                                // Replace M in place: no bubble between beats.
                                m_ctrl_r <= in_ctrl;
                                m_data_r <= in_data;
                            end else if (in_fire_s) begin
                                s_ctrl_r <= in_ctrl;
                                s_data_r <= in_data;
                                state_r  <= ST_FULL2;
                            end else if (out_fire_s) begin
                                state_r  <= ST_EMPTY;
                            end
                        end
                        ST_FULL2: begin
                            if (out_fire_s) begin
                                m_ctrl_r <= s_ctrl_r;
                                m_data_r <= s_data_r;
                                state_r  <= ST_FULL;
                            end
                        end
                        default: begin
                            state_r <= ST_EMPTY;
                        end
                    endcase
                end
            end

            // in_ready comes straight from state; flush only gates it.
            assign in_ready_s = (state_r != ST_FULL2) & ~flush;
            assign m_valid_s  = (state_r != ST_EMPTY);
        end else begin : g_single
            logic valid_r;

            // Single entry: loads on accept, empties when drained with no refill.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_r  <= 1'b0;
                    m_ctrl_r <= '0;
                    m_data_r <= '0;
                end else if (flush) begin
                    valid_r  <= 1'b0;
                    m_ctrl_r <= '0;
                    if (FLUSH_CLR_DATA != 0) begin
                        m_data_r <= '0;
                    end
                end else if (in_fire_s) begin
                    valid_r  <= 1'b1;
                    m_ctrl_r <= in_ctrl;
                    m_data_r <= in_data;
                end else if (out_fire_s) begin
                    valid_r  <= 1'b0;
                end
            end

            assign in_ready_s = (~valid_r | out_ready) & ~flush;
            assign m_valid_s  = valid_r;
        end
    endgenerate

    // Bubble rule: control is zero whenever no beat is presented.
    always_comb begin
        out_ctrl = '0;
        if (m_valid_s) begin
            out_ctrl = m_ctrl_r;
        end else begin
            out_ctrl = '0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = m_valid_s;
    assign out_data  = m_data_r;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (m_valid_s & ~out_ready),
        .cnt   (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (~m_valid_s),
        .cnt   (bubble_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for the 5-stage MIPS pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Supports valid/ready backpressure, an optional skid entry and synchronous flush.
- Flush and empty slots always present all-zero control, so downstream writes are suppressed.
- Saturating stall and bubble counters provide performance visibility.

Parameters:
- CTRL_W, 8: width of the control bundle (regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol...). Zeroed on bubble/flush.
- DATA_W, 128: width of the data bundle (operands, register indices, immediates).
- SKID, 1: 1 = two-entry skid (registered in_ready, full throughput); 0 = single entry (combinational in_ready).
- FLUSH_CLR_DATA, 0: 1 = flush also zeroes stored data; 0 = data is left unchanged.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all held and incoming beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control; all-zero whenever out_valid=0
- out_data  out  DATA_W  data bundle
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
- bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- Reset (Already decided): reset rst, synchronous, active-low; clock clk.
  - When rst=0 at a clk edge, all entries become invalid and all ctrl/data are zeroed.
  - Counters clear to 0.
  - After reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Latency from in_fire to out_valid is 1 cycle.
  - Beats leave in acceptance order; no drop or duplicate except on flush.
- SKID=1 state machine (main entry M, skid entry S):
  - EMPTY: in_fire loads M, go to FULL.
  - FULL: in_fire with out_fire reloads M, stay FULL. in_fire without out_fire loads S, go to FULL2. out_fire without in_fire, go to EMPTY.
  - FULL2: in_ready=0. out_fire moves S into M, go to FULL.
  - in_ready = !(state==FULL2) & !flush. in_ready is registered state, with flush gating only.
- SKID=0:
  - Single entry M.
  - in_ready = (!out_valid | out_ready) & !flush.
  - in_fire loads M. out_fire without in_fire empties M.
- Flush:
  - Synchronous. Priority below reset, above all other events.
  - All entries become invalid and ctrl is zeroed.
  - Data is zeroed only if FLUSH_CLR_DATA=1.
  - in_ready=0 during flush, so no beat is accepted that cycle.
  - Next cycle: out_valid=0, state EMPTY.
  - out_fire in the flush cycle is still a completed transfer downstream.
- Bubble rule: out_ctrl = out_valid ? M.ctrl : 0, forced combinationally.
- Stall hold: while out_valid & !out_ready, out_ctrl and out_data are stable.
- Counters:
  - Each cycle rst=1: stall_cnt+1 if out_valid & !out_ready; bubble_cnt+1 if !out_valid.
  - Both saturate at 2^CNT_W-1.
  - Flush does not clear them.
- Simultaneous in_fire and out_fire in FULL: the new beat replaces M with no bubble, giving 100% throughput.
- Reset mid-transfer: all beats are lost. in_ready goes to 1 in the following cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - WIDTH (32).
  - Control bundle typedefs and widths per stage (CTRL_ID2EXE_W etc.).
  - Encoding constants for the state machine (ST_EMPTY, ST_FULL, ST_FULL2).
- One sub-module, pipe_sat_counter (CNT_W, increment enable, synchronous active-low clear), instantiated twice.
- Skid logic stays inline under a SKID generate.

Test Plan:
1. Reset, then out_ready=1 and in_valid=1 for 4 cycles with ctrl=8'hA1..A4 -> out_valid from cycle 1, out_ctrl A1..A4 consecutively, bubble_cnt=1.
2. SKID=1: send A1, A2, A3 with out_ready=0 -> A1 held in M, A2 in S, in_ready=0 after A2, stall_cnt increments each cycle. Then out_ready=1 -> A1, A2, A3 in order, no loss.
3. State FULL2, pulse flush for 1 cycle with in_valid=1 -> next cycle out_valid=0 and out_ctrl=0. out_data unchanged (FLUSH_CLR_DATA=0) or 0 (=1). Incoming beat not accepted.
4. SKID=0, continuous streaming with out_ready toggling 1,0,1,0 -> in_ready mirrors (!out_valid|out_ready), no duplicate or dropped beat, data/ctrl stable while stalled.
5. CNT_W=4: hold out_valid=0 for 20 cycles -> bubble_cnt saturates at 15.
6. Assert rst=0 in FULL2 mid-stream -> next cycle out_valid=0, out_ctrl=0, out_data=0, counters 0, in_ready=1.
